// File: rtl/spart_ctrl.sv
// spart_ctrl: processor-side driver for a SPART (simple UART).
// After reset it programs the SPART baud divisor selected by br_cfg. It then
// echoes every received byte back to the SPART through a 4-entry FIFO.
//
// Ports:
//   clk       - sole clock, rising edge
//   rst       - synchronous active-high reset
//   br_cfg    - baud select (quasi-static); a change triggers reprogramming
//   rda       - SPART receive data available
//   tbr       - SPART transmit buffer ready
//   iocs      - SPART chip select, high for exactly one clk per bus cycle
//   iorw      - 1 = read from SPART, 0 = write to SPART
//   ioaddr    - 00 tx/rx buffer, 01 status (unused), 10 div low, 11 div high
//   databus   - shared bus, driven only during write cycles
//   cfg_done  - divisor for the current br_cfg has been programmed
//   fifo_cnt  - bytes held in the echo FIFO (0..4)
module spart_ctrl #(
  parameter logic [15:0] DIV0 = 16'd10416,
  parameter logic [15:0] DIV1 = 16'd5207,
  parameter logic [15:0] DIV2 = 16'd2603,
  parameter logic [15:0] DIV3 = 16'd1301
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] br_cfg,
  input  logic       rda,
  input  logic       tbr,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  inout  logic [7:0] databus,
  output logic       cfg_done,
  output logic [2:0] fifo_cnt
);

  typedef enum logic [2:0] {
    CFG_LO,
    CFG_HI,
    IDLE,
    RX_READ,
    RX_GAP,
    TX_WRITE,
    TX_GAP
  } state_t;

  state_t     state;
  logic [1:0] cfg_reg;
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [7:0] fifo_mem [4];
  logic [7:0] dout;

  logic [15:0] div_new;
  logic [15:0] div_cur;
  logic        push;
  logic        pop;

  function automatic logic [15:0] div_sel(input logic [1:0] sel);
    case (sel)
      2'b00:   div_sel = DIV0;
      2'b01:   div_sel = DIV1;
      2'b10:   div_sel = DIV2;
      default: div_sel = DIV3;
    endcase
  endfunction

  // Low byte uses the br_cfg about to be latched, high byte the latched copy,
  // so both halves always come from the same divisor.
  always_comb begin
    div_new = div_sel(br_cfg);
    div_cur = div_sel(cfg_reg);
  end

  // The bus outputs are registered, so the cycle currently on the bus closes
  // at the coming edge: a buffer read pushes, a buffer write pops.
  always_comb begin
    push = iocs &&  iorw && (ioaddr == 2'b00);
    pop  = iocs && !iorw && (ioaddr == 2'b00);
  end

  assign databus = (iocs && !iorw) ? dout : 'z;

  // The state names the bus cycle launched at the next edge; e.g. while the
  // read is on the bus the state is already RX_GAP, whose edge closes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CFG_LO;
      cfg_done <= 1'b0;
      cfg_reg  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      iocs     <= 1'b0;
      iorw     <= 1'b1;
      ioaddr   <= '0;
      dout     <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= databus;
        wr_ptr           <= wr_ptr + 2'd1;
        fifo_cnt         <= fifo_cnt + 3'd1;
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + 2'd1;
        fifo_cnt <= fifo_cnt - 3'd1;
      end

      iocs   <= 1'b0;
      iorw   <= 1'b1;
      ioaddr <= 2'b00;

      case (state)
        CFG_LO: begin
          iocs    <= 1'b1;
          iorw    <= 1'b0;
          ioaddr  <= 2'b10;
          dout    <= div_new[7:0];
          cfg_reg <= br_cfg;
          state   <= CFG_HI;
        end
        CFG_HI: begin
          iocs     <= 1'b1;
          iorw     <= 1'b0;
          ioaddr   <= 2'b11;
          dout     <= div_cur[15:8];
          cfg_done <= 1'b1;
          state    <= IDLE;
        end
        IDLE: begin
          if (br_cfg != cfg_reg) begin
            cfg_done <= 1'b0;
            state    <= CFG_LO;
          end else if (rda && (fifo_cnt < 3'd4)) begin
            state <= RX_READ;
          end else if (tbr && (fifo_cnt != 3'd0)) begin
            state <= TX_WRITE;
          end
        end
        RX_READ: begin
          iocs   <= 1'b1;
          iorw   <= 1'b1;
          ioaddr <= 2'b00;
          state  <= RX_GAP;
        end
        RX_GAP: begin
          state <= IDLE;
        end
        TX_WRITE: begin
          iocs   <= 1'b1;
          iorw   <= 1'b0;
          ioaddr <= 2'b00;
          dout   <= fifo_mem[rd_ptr];
          state  <= TX_GAP;
        end
        TX_GAP: begin
          state <= IDLE;
        end
        default: begin
          state <= CFG_LO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spart_ctrl.sv
module tb_spart_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] br_cfg = 2'b01;
  logic       rda = 1'b0;
  logic       tbr = 1'b0;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  wire  [7:0] databus;
  logic       cfg_done;
  logic [2:0] fifo_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int reads    = 0;

  logic [7:0] rx_q[$];
  logic [7:0] tx_log[$];
  logic [1:0] cfg_addr_q[$];
  logic [7:0] cfg_data_q[$];
  logic [7:0] rx_head = 8'h00;
  logic       prev_iocs = 1'b0;
  logic [1:0] prev_addr = 2'b00;

  // SPART model drives the bus whenever the controller must not: the received
  // byte during buffer reads, a marker pattern otherwise.
  logic       tb_en;
  logic [7:0] tb_val;
  assign tb_en   = !(iocs && !iorw);
  assign tb_val  = (iocs && iorw && ioaddr == 2'b00) ? rx_head : 8'h3C;
  assign databus = tb_en ? tb_val : 8'hzz;

  spart_ctrl #(
    .DIV0(16'd10416),
    .DIV1(16'd5207),
    .DIV2(16'd2603),
    .DIV3(16'd1301)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .br_cfg  (br_cfg),
    .rda     (rda),
    .tbr     (tbr),
    .iocs    (iocs),
    .iorw    (iorw),
    .ioaddr  (ioaddr),
    .databus (databus),
    .cfg_done(cfg_done),
    .fifo_cnt(fifo_cnt)
  );

  always #5 clk = ~clk;

  // SPART model plus bus checker, sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (iocs && iorw && ioaddr == 2'b00) begin
      reads++;
      if (rx_q.size() > 0) rx_q.delete(0);
    end else begin
      rx_head = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
    end
    rda = (rx_q.size() > 0);
    if (iocs && !iorw && ioaddr == 2'b00) tx_log.push_back(databus);
    if (iocs && !iorw && ioaddr[1]) begin
      cfg_addr_q.push_back(ioaddr);
      cfg_data_q.push_back(databus);
    end
    n_checks++;
    if (iocs && ioaddr == 2'b01)
      $display("FAIL status_access: ioaddr=%b at cycle %0d, required never 01", ioaddr, cyc);
    if (iocs && ioaddr == 2'b01) n_fail++;
    n_checks++;
    if (tb_en && databus !== tb_val) begin
      n_fail++;
      $display("FAIL bus_release: databus=%h required %h (iocs=%b iorw=%b) cycle %0d",
               databus, tb_val, iocs, iorw, cyc);
    end
    if (prev_iocs && iocs) begin
      n_checks++;
      if (!(prev_addr == 2'b10 && ioaddr == 2'b11)) begin
        n_fail++;
        $display("FAIL iocs_back_to_back: addr %b then %b at cycle %0d, required 10 then 11",
                 prev_addr, ioaddr, cyc);
      end
    end
    prev_iocs = iocs;
    prev_addr = ioaddr;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; br_cfg = 2'b01; tbr = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({iocs, iorw, ioaddr} !== 4'b0100) begin
      n_fail++; $display("FAIL reset_bus: got %b required 0100", {iocs, iorw, ioaddr});
    end
    n_checks++;
    if (cfg_done !== 1'b0) begin
      n_fail++; $display("FAIL reset_cfg_done: got %b required 0", cfg_done);
    end
    n_checks++;
    if (fifo_cnt !== 3'd0) begin
      n_fail++; $display("FAIL reset_fifo_cnt: got %0d required 0", fifo_cnt);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if ({iocs, iorw, ioaddr} !== 4'b1010 || databus !== 8'h57) begin
      n_fail++; $display("FAIL cfg_lo_write: ctl=%b data=%h required 1010 57",
                         {iocs, iorw, ioaddr}, databus);
    end
    n_checks++;
    if (cfg_done !== 1'b0) begin
      n_fail++; $display("FAIL cfg_done_early: got %b required 0", cfg_done);
    end
    tick();
    n_checks++;
    if ({iocs, iorw, ioaddr} !== 4'b1011 || databus !== 8'h14) begin
      n_fail++; $display("FAIL cfg_hi_write: ctl=%b data=%h required 1011 14",
                         {iocs, iorw, ioaddr}, databus);
    end
    tick();
    n_checks++;
    if (iocs !== 1'b0 || cfg_done !== 1'b1) begin
      n_fail++; $display("FAIL cfg_complete: iocs=%b cfg_done=%b required 0 1", iocs, cfg_done);
    end
  endtask

  task automatic test_single_echo();
    int t;
    int rk;
    tbr = 1'b1;
    rx_q.push_back(8'hA5);
    for (t = 0; t < 20 && !(iocs && iorw && ioaddr == 2'b00); t++) tick();
    rk = cyc;
    n_checks++;
    if (t >= 20) begin
      n_fail++; $display("FAIL echo_read_timeout: no read cycle, required one within 20");
    end
    tick();
    n_checks++;
    if (fifo_cnt !== 3'd1) begin
      n_fail++; $display("FAIL echo_fifo_cnt1: got %0d required 1", fifo_cnt);
    end
    for (t = 0; t < 20 && !(iocs && !iorw && ioaddr == 2'b00); t++) tick();
    n_checks++;
    if (t >= 20 || databus !== 8'hA5) begin
      n_fail++; $display("FAIL echo_write: data=%h required a5", databus);
    end
    n_checks++;
    if (cyc - rk !== 3) begin
      n_fail++; $display("FAIL echo_latency: got %0d cycles required 3", cyc - rk);
    end
    tick();
    n_checks++;
    if (fifo_cnt !== 3'd0) begin
      n_fail++; $display("FAIL echo_fifo_cnt0: got %0d required 0", fifo_cnt);
    end
  endtask

  task automatic test_fifo_full();
    int t;
    int r0;
    tbr = 1'b0;
    tx_log.delete();
    r0 = reads;
    for (int i = 1; i <= 5; i++) rx_q.push_back(8'(i));
    repeat (40) tick();
    n_checks++;
    if (fifo_cnt !== 3'd4) begin
      n_fail++; $display("FAIL full_fifo_cnt: got %0d required 4", fifo_cnt);
    end
    n_checks++;
    if (reads - r0 !== 4) begin
      n_fail++; $display("FAIL full_reads: got %0d required 4", reads - r0);
    end
    n_checks++;
    if (rda !== 1'b1) begin
      n_fail++; $display("FAIL full_rda_pending: got %b required 1", rda);
    end
    tbr = 1'b1;
    for (t = 0; t < 100 && tx_log.size() < 5; t++) tick();
    n_checks++;
    if (tx_log.size() !== 5) begin
      n_fail++; $display("FAIL full_drain_count: got %0d writes required 5", tx_log.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (tx_log[i] !== 8'(i + 1)) begin
          n_fail++; $display("FAIL full_order[%0d]: got %h required %h", i, tx_log[i], 8'(i + 1));
        end
      end
    end
    tick();
    n_checks++;
    if (fifo_cnt !== 3'd0) begin
      n_fail++; $display("FAIL full_drained: got %0d required 0", fifo_cnt);
    end
  endtask

  task automatic test_reconfig();
    int t;
    int low;
    tbr = 1'b0;
    rx_q.push_back(8'h11);
    rx_q.push_back(8'h22);
    for (t = 0; t < 40 && fifo_cnt != 3'd2; t++) tick();
    repeat (3) tick();
    cfg_addr_q.delete();
    cfg_data_q.delete();
    br_cfg = 2'b11;
    low = 0;
    repeat (10) begin
      tick();
      if (!cfg_done) low++;
    end
    n_checks++;
    if (cfg_addr_q.size() !== 2) begin
      n_fail++; $display("FAIL reconfig_writes: got %0d cfg writes required 2", cfg_addr_q.size());
    end else begin
      n_checks++;
      if (cfg_addr_q[0] !== 2'b10 || cfg_data_q[0] !== 8'h15) begin
        n_fail++; $display("FAIL reconfig_lo: addr=%b data=%h required 10 15",
                           cfg_addr_q[0], cfg_data_q[0]);
      end
      n_checks++;
      if (cfg_addr_q[1] !== 2'b11 || cfg_data_q[1] !== 8'h05) begin
        n_fail++; $display("FAIL reconfig_hi: addr=%b data=%h required 11 05",
                           cfg_addr_q[1], cfg_data_q[1]);
      end
    end
    n_checks++;
    if (low !== 2) begin
      n_fail++; $display("FAIL reconfig_cfg_done_low: got %0d cycles required 2", low);
    end
    n_checks++;
    if (fifo_cnt !== 3'd2) begin
      n_fail++; $display("FAIL reconfig_fifo_kept: got %0d required 2", fifo_cnt);
    end
    tx_log.delete();
    tbr = 1'b1;
    for (t = 0; t < 40 && tx_log.size() < 2; t++) tick();
    n_checks++;
    if (tx_log.size() !== 2) begin
      n_fail++; $display("FAIL reconfig_echo_count: got %0d required 2", tx_log.size());
    end else if (tx_log[0] !== 8'h11 || tx_log[1] !== 8'h22) begin
      n_fail++; $display("FAIL reconfig_echo_data: got %h %h required 11 22", tx_log[0], tx_log[1]);
    end
  endtask

  task automatic test_reset_mid_write();
    int t;
    tbr = 1'b0;
    rx_q.push_back(8'h77);
    rx_q.push_back(8'h88);
    for (t = 0; t < 40 && fifo_cnt != 3'd2; t++) tick();
    tbr = 1'b1;
    for (t = 0; t < 40 && !(iocs && !iorw && ioaddr == 2'b00); t++) tick();
    n_checks++;
    if (t >= 40) begin
      n_fail++; $display("FAIL midrst_no_write: no write cycle, required one within 40");
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if (iocs !== 1'b0 || fifo_cnt !== 3'd0 || cfg_done !== 1'b0) begin
      n_fail++; $display("FAIL midrst_state: iocs=%b fifo_cnt=%0d cfg_done=%b required 0 0 0",
                         iocs, fifo_cnt, cfg_done);
    end
    tbr = 1'b0;
    rst = 1'b0;
    tick();
    n_checks++;
    if ({iocs, iorw, ioaddr} !== 4'b1010 || databus !== 8'h15) begin
      n_fail++; $display("FAIL midrst_cfg_lo: ctl=%b data=%h required 1010 15",
                         {iocs, iorw, ioaddr}, databus);
    end
    repeat (4) tick();
  endtask

  initial begin
    test_reset();
    test_single_echo();
    test_fifo_full();
    test_reconfig();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spart_ctrl.md
SPART_CTRL -- requirements
Module: spart_ctrl

Interface
REQ-001 Parameter DIV0, default 16'd10416, divisor for br_cfg=00 (4800 baud at 50 MHz).
REQ-002 Parameter DIV1, default 16'd5207, divisor for br_cfg=01 (9600 baud).
REQ-003 Parameter DIV2, default 16'd2603, divisor for br_cfg=10 (19200 baud).
REQ-004 Parameter DIV3, default 16'd1301, divisor for br_cfg=11 (38400 baud).
REQ-005 clk  input  1  sole clock; all logic on rising edge.
REQ-006 rst  input  1  reset; synchronous, active-high.
REQ-007 br_cfg  input  2  baud select, quasi-static switch input.
REQ-008 rda  input  1  SPART receive data available.
REQ-009 tbr  input  1  SPART transmit buffer ready.
REQ-010 iocs  output  1  SPART chip select; high only during a bus cycle.
REQ-011 iorw  output  1  1 = read from SPART, 0 = write to SPART.
REQ-012 ioaddr  output  2  00 tx/rx buffer, 01 status, 10 divisor low, 11 divisor high.
REQ-013 databus  inout  8  shared bus; driven only during write cycles, otherwise Z.
REQ-014 cfg_done  output  1  high once divisor for current br_cfg is programmed.
REQ-015 fifo_cnt  output  3  number of bytes held in echo FIFO (0..4).

Function
REQ-016 Block SHALL be a processor-side driver: program SPART divisor, then echo every received byte back via a 4-entry FIFO.
REQ-017 Bus cycle SHALL last exactly one clk with iocs=1; idle bus SHALL be iocs=0, iorw=1, ioaddr=00, databus=Z.
REQ-018 States SHALL be CFG_LO, CFG_HI, IDLE, RX_READ, RX_GAP, TX_WRITE, TX_GAP.
REQ-019 CFG_LO SHALL write selected divisor[7:0] to ioaddr=10, latch br_cfg into cfg_reg, go to CFG_HI.
REQ-020 CFG_HI SHALL write divisor[15:8] to ioaddr=11, set cfg_done=1, go to IDLE.
REQ-021 Divisor SHALL be selected from cfg_reg-to-be (current br_cfg) in CFG_LO and from cfg_reg in CFG_HI, so both halves match.
REQ-022 IDLE priority: br_cfg!=cfg_reg -> CFG_LO (cfg_done=0); else rda && fifo_cnt<4 -> RX_READ; else tbr && fifo_cnt>0 -> TX_WRITE; else stay.
REQ-023 RX_READ SHALL drive iocs=1, iorw=1, ioaddr=00 and on the closing clk edge push databus into FIFO tail, fifo_cnt+1; go to RX_GAP.
REQ-024 TX_WRITE SHALL drive iocs=1, iorw=0, ioaddr=00, databus=FIFO head, pop on closing edge, fifo_cnt-1; go to TX_GAP.
REQ-025 RX_GAP/TX_GAP SHALL last one clk with idle bus, ignoring rda/tbr, then go to IDLE (covers SPART flag deassert latency).
REQ-026 FIFO SHALL be 4x8, 2-bit wrapping read/write pointers, byte order preserved across wrap.
REQ-027 Push and pop SHALL never occur in the same cycle; no push when fifo_cnt=4, no pop when fifo_cnt=0.
REQ-028 FIFO full SHALL leave rda pending (byte stays in SPART), no data loss inside block.
REQ-029 Reconfiguration SHALL preserve FIFO contents and pointers.
REQ-030 Status register (ioaddr=01) SHALL not be accessed; rda/tbr pins are used directly.
REQ-031 Minimum RX-to-echo latency: rda high in IDLE with tbr high -> TX_WRITE begins 3 clk later.

Reset
REQ-032 On rst=1 at a clk edge: state=CFG_LO, cfg_done=0, fifo_cnt=0, pointers=0, cfg_reg=00, bus idle.
REQ-033 rst SHALL override any state including mid bus cycle; no partial write completes after reset edge.
REQ-034 First clk after rst deasserts SHALL be the CFG_LO write cycle.

Verification
REQ-035 Reset release, br_cfg=01 -> cycle 1: iocs=1, iorw=0, ioaddr=10, databus=8'h57; cycle 2: ioaddr=11, databus=8'h14; cfg_done=1 after.
REQ-036 Model SPART supplies 8'hA5 with rda=1, tbr=1 -> one read cycle, fifo_cnt=1, then write cycle with databus=8'hA5, fifo_cnt=0.
REQ-037 tbr held 0, five bytes 01..05 offered -> four reads, fifo_cnt=4, rda stays pending; raise tbr -> writes 01,02,03,04 then 05 read and echoed in order.
REQ-038 br_cfg 01->11 while fifo_cnt=2 -> writes 8'h15 to ioaddr 10, 8'h05 to 11; cfg_done low for exactly those 2 cycles; FIFO bytes echoed afterwards unchanged.
REQ-039 rst asserted during TX_WRITE -> next cycle bus idle, fifo_cnt=0, CFG_LO write follows release.
REQ-040 Bus checker all tests: databus Z whenever iorw=1 or iocs=0; iocs never high two consecutive cycles except CFG_LO->CFG_HI.
